clause_bcp_engine: RTL

CLAUSE_BCP_ENGINE -- requirements
Module: clause_bcp_engine

---
 rtl/clause_bcp_engine.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/clause_bcp_engine.sv
// Boolean constraint propagation step for one clause word: assign one literal,
// write the word back if it changed, then classify the clause.
// Optional unit-implication detection is compiled in with `define BCP_UNIT_IMPLY_EN.
module clause_bcp_engine #(
    parameter int unsigned NLIT   = 4,
    parameter int unsigned ADDR_W = 16,
    localparam int unsigned DW    = 3 * NLIT,
    localparam int unsigned OW    = $clog2(NLIT)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [OW-1:0]     OFFSET,
    input  logic              VALUE,
    input  logic [ADDR_W-1:0] BASE,
    output logic              MEM_RD,
    output logic              MEM_WR,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DW-1:0]     MEM_WDATA,
    input  logic [DW-1:0]     MEM_RDATA,
    input  logic              MEM_RVALID,
    output logic              BUSY,
    output logic              DONE,
    output logic [1:0]        RESULT,
    output logic [OW-1:0]     IMPLY_OFFSET,
    output logic              IMPLY_VALUE
);

    localparam logic [1:0] RES_OPEN     = 2'b00;
    localparam logic [1:0] RES_SAT      = 2'b01;
    localparam logic [1:0] RES_UNIT     = 2'b10;
    localparam logic [1:0] RES_CONFLICT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_CHECK, S_WRITE, S_EVAL, S_FIN
    } state_t;

    state_t              state;
    logic [OW-1:0]       offset_q;
    logic                value_q;
    logic [ADDR_W-1:0]   base_q;
    logic [DW-1:0]       word_q;

    logic [NLIT-1:0]     val_w;
    logic [NLIT-1:0]     asg_w;
    logic [NLIT-1:0]     pol_w;
    logic [NLIT-1:0]     sel;
    logic                off_ok;
    logic                slot_assigned;
    logic                slot_matches;
    logic [DW-1:0]       upd_word;
    logic                any_true;
    logic                all_assigned;
    logic [1:0]          eval_res;

    assign val_w = word_q[NLIT-1:0];
    assign asg_w = word_q[2*NLIT-1:NLIT];
    assign pol_w = word_q[3*NLIT-1:2*NLIT];

    // One-hot select of the requested slot; an out-of-range offset selects nothing
    assign sel           = NLIT'(1) << offset_q;
    assign off_ok        = (32'(offset_q) < 32'(NLIT));
    assign slot_assigned = |(asg_w & sel);
    assign slot_matches  = (|(val_w & sel)) == value_q;

    // Word with the requested literal assigned
    always_comb begin
        upd_word = word_q;
        upd_word[2*NLIT-1:NLIT] = asg_w | sel;
        upd_word[NLIT-1:0]      = value_q ? (val_w | sel) : (val_w & ~sel);
    end

    assign any_true     = |(asg_w & ~(val_w ^ pol_w));
    assign all_assigned = &asg_w;

`ifdef BCP_UNIT_IMPLY_EN
    logic                unit_one;
    logic [OW-1:0]       unit_idx;
    logic                unit_pol;

    // Locate the single unassigned literal, if exactly one exists
    always_comb begin
        logic found;
        logic multi;
        found    = 1'b0;
        multi    = 1'b0;
        unit_idx = '0;
        for (int i = 0; i < int'(NLIT); i++) begin
            if (!asg_w[i]) begin
                if (found) begin
                    multi = 1'b1;
                end else begin
                    found    = 1'b1;
                    unit_idx = OW'(i);
                end
            end
        end
        unit_one = found && !multi;
    end

    assign unit_pol = |(pol_w & (NLIT'(1) << unit_idx));
`endif

    // Clause classification with true-literal priority over conflict and unit
    always_comb begin
        eval_res = RES_OPEN;
        if (any_true) begin
            eval_res = RES_SAT;
        end else if (all_assigned) begin
            eval_res = RES_CONFLICT;
`ifdef BCP_UNIT_IMPLY_EN
        end else if (unit_one) begin
            eval_res = RES_UNIT;
`endif
        end
    end

    // Control FSM with registered memory strobes and status
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= S_IDLE;
            offset_q     <= '0;
            value_q      <= 1'b0;
            base_q       <= '0;
            word_q       <= '0;
            MEM_RD       <= 1'b0;
            MEM_WR       <= 1'b0;
            MEM_ADDR     <= '0;
            MEM_WDATA    <= '0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            RESULT       <= RES_OPEN;
            IMPLY_OFFSET <= '0;
            IMPLY_VALUE  <= 1'b0;
        end else begin
            MEM_RD    <= 1'b0;
            MEM_WR    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            DONE      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        offset_q     <= OFFSET;
                        value_q      <= VALUE;
                        base_q       <= BASE;
                        RESULT       <= RES_OPEN;
                        IMPLY_OFFSET <= '0;
                        IMPLY_VALUE  <= 1'b0;
                        MEM_RD       <= 1'b1;
                        MEM_ADDR     <= BASE;
                        BUSY         <= 1'b1;
                        state        <= S_READ;
                    end
                end
                S_READ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (MEM_RVALID) begin
                        word_q <= MEM_RDATA;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!off_ok || (slot_assigned && !slot_matches)) begin
                        RESULT <= RES_CONFLICT;
                        DONE   <= 1'b1;
                        state  <= S_FIN;
                    end else if (slot_assigned) begin
                        state <= S_EVAL;
                    end else begin
                        word_q    <= upd_word;
                        MEM_WR    <= 1'b1;
                        MEM_ADDR  <= base_q;
                        MEM_WDATA <= upd_word;
                        state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    state <= S_EVAL;
                end
                S_EVAL: begin
                    RESULT <= eval_res;
`ifdef BCP_UNIT_IMPLY_EN
                    if (eval_res == RES_UNIT) begin
                        IMPLY_OFFSET <= unit_idx;
                        IMPLY_VALUE  <= unit_pol;
                    end
`endif
                    DONE  <= 1'b1;
                    state <= S_FIN;
                end
                S_FIN: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
